midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
- Parametrised successor to the fixed four-voice note dispatch in the MIDI player.
- Takes complete 3-byte MIDI messages from midi_msg_capture and assigns note-on/note-off events to NUM_VOICES voice slots.
- Adds retrigger, release-aware allocation, oldest-voice stealing, channel filtering, sustain pedal (CC64) and all-notes-off (CC123).
- Drives one voice-update write per event into the note register / midi_note array.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..32).
- ADDR_W, 2, slot index width; must equal ceil(log2(NUM_VOICES)).
- CHANNEL_MASK, 16'hFFFF, bit n set = accept MIDI channel n.
- AGE_W, 8, per-slot age counter width; the counter saturates.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- new_msg  in  1  one-cycle strobe; msg valid.
- msg  in  24  [23:16] status, [15:8] data1 (note/controller), [7:0] data2 (velocity/value).
- voice_busy  in  NUM_VOICES  per-voice note_playing from midi_note instances (high during attack through release).
- voice_wr_en  out  1  one-cycle write strobe.
- voice_wr_addr  out  ADDR_W  target slot.
- voice_note  out  7  note number.
- voice_vel  out  7  velocity.
- voice_gate  out  1  1 = note on/retrigger, 0 = release.
- voices_active  out  NUM_VOICES  slot holds a keyed note (gate on, including sustained).
- sustain_active  out  1  CC64 pedal state.
- busy  out  1  high whenever FSM is not IDLE.
- dropped_msg  out  1  one-cycle pulse when new_msg arrives while busy.

Behaviour:
- Reset: all outputs 0. Slot tables cleared: active=0, sustained=0, note=0, age=0. FSM goes to IDLE. Reset mid-operation aborts the event; no write is issued.
- Decode, in IDLE on new_msg:
  - Status 0x9n with data2≠0 is NOTE_ON.
  - Status 0x8n, or 0x9n with data2=0, is NOTE_OFF.
  - 0xBn with data1=64 is SUSTAIN; 0xBn with data1=123 is ALL_OFF.
  - Anything else, or CHANNEL_MASK[n]=0, is ignored: stay IDLE, busy stays 0.
- States: IDLE → DECODE (1 cycle) → SCAN (exactly NUM_VOICES cycles, slot i examined in cycle i) → WRITE (1 cycle, voice_wr_en=1) → IDLE.
- Latency: new_msg at cycle t gives voice_wr_en at t+2+NUM_VOICES. busy rises at t+1 and falls at t+3+NUM_VOICES.
- NOTE_ON slot priority during SCAN:
  1. An active slot with the same note: retrigger.
  2. Lowest-index free slot (active=0 and voice_busy=0).
  3. Inactive slot still releasing (voice_busy=1) with the largest age.
  4. Steal the active slot with the largest age.
  - Ties at steps 3 and 4 go to the lowest index.
- NOTE_ON write: gate=1, vel=data2[6:0]. Chosen slot gets active=1, sustained=0, age=0. Every other slot's age increments, saturating at 2^AGE_W−1.
- NOTE_OFF: SCAN finds the lowest-index active, non-sustained slot with the matching note.
  - No match: skip WRITE, return to IDLE.
  - Match with sustain_active=1: set sustained=1, no write.
  - Match otherwise: write gate=0, vel=0, and clear active.
- SUSTAIN, value≥64: set sustain_active and return to IDLE after DECODE.
- SUSTAIN, value<64: clear sustain_active, then enter RELEASE.
  - RELEASE lasts NUM_VOICES cycles and visits slot i in cycle i.
  - Each slot with sustained=1 gets a gate=0 write in that cycle; its active and sustained are cleared.
- ALL_OFF: RELEASE-style sweep; every active slot is written with gate=0 and cleared; sustained is cleared.
- new_msg while busy: message discarded, dropped_msg pulses the same cycle, slot tables unchanged.
- voices_active[i] mirrors active[i] and updates the cycle after the WRITE or RELEASE write.

Test Plan:
- Reset, then NOTE_ON 0x90/60/100 with voice_busy=0 → wr_en at t+6 (N=4), addr=0, note=60, vel=100, gate=1; voices_active=0001.
- Five NOTE_ONs, notes 60..64, all voice_busy high while active → fifth (64) steals slot 0 (oldest); wr addr=0, note=64.
- NOTE_ON 60 twice → second write targets the same slot (retrigger); voices_active unchanged.
- Sustain on (0xB0/64/127), NOTE_OFF 60 → no write; sustain off (0xB0/64/0) → single gate=0 write to 60's slot during the RELEASE sweep; busy deasserts after 4 sweep cycles.
- NOTE_ON 0x91 with CHANNEL_MASK=16'h0001 → ignored, busy stays 0; 0x90 with velocity 0 → treated as NOTE_OFF.
- Second new_msg one cycle after the first → dropped_msg=1 for one cycle; only the first message is written. Reset asserted mid-SCAN → no wr_en; all outputs 0 the next cycle.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: maps note/controller messages onto voice slots
// with retrigger, release-aware allocation, stealing, sustain and all-off.
module midi_voice_allocator #(
    parameter int          NUM_VOICES   = 4,
    parameter int          ADDR_W       = 2,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter int          AGE_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_msg,
    input  logic [23:0]           msg,
    input  logic [NUM_VOICES-1:0] voice_busy,
    output logic                  voice_wr_en,
    output logic [ADDR_W-1:0]     voice_wr_addr,
    output logic [6:0]            voice_note,
    output logic [6:0]            voice_vel,
    output logic                  voice_gate,
    output logic [NUM_VOICES-1:0] voices_active,
    output logic                  sustain_active,
    output logic                  busy,
    output logic                  dropped_msg
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_SCAN, S_WRITE, S_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_ON, EV_OFF, EV_SUS_ON, EV_SUS_OFF, EV_ALL_OFF
    } ev_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_VOICES - 1);

    state_t r_state, w_next;
    ev_t    r_ev, w_ev;

    logic [6:0]            r_note, r_vel;
    logic [ADDR_W-1:0]     r_idx;
    logic [NUM_VOICES-1:0] r_active, r_sus;
    logic [6:0]            r_tab_note [NUM_VOICES];
    logic [AGE_W-1:0]      r_age      [NUM_VOICES];
    logic                  r_sustain;

    logic              r_hit_f, r_free_f, r_rel_f, r_old_f;
    logic [ADDR_W-1:0] r_hit_i, r_free_i, r_rel_i, r_old_i;
    logic [AGE_W-1:0]  r_rel_age, r_old_age;

    logic              w_hit_f, w_free_f, w_rel_f, w_old_f;
    logic [ADDR_W-1:0] w_hit_i, w_free_i, w_rel_i, w_old_i;
    logic [AGE_W-1:0]  w_rel_age, w_old_age;

    logic              w_last, w_match, w_rel_hit;
    logic [ADDR_W-1:0] w_sel;

    assign w_last         = (r_idx == LAST);
    assign voices_active  = r_active;
    assign sustain_active = r_sustain;
    assign busy           = (r_state != S_IDLE);
    assign dropped_msg    = new_msg && busy;

    always_comb begin
        w_ev = EV_NONE;
        if (CHANNEL_MASK[msg[19:16]]) begin
            case (msg[23:20])
                4'h9: w_ev = (msg[7:0] != 8'd0) ? EV_ON : EV_OFF;
                4'h8: w_ev = EV_OFF;
                4'hB: begin
                    if (msg[15:8] == 8'd64)
                        w_ev = (msg[7:0] >= 8'd64) ? EV_SUS_ON : EV_SUS_OFF;
                    else if (msg[15:8] == 8'd123)
                        w_ev = EV_ALL_OFF;
                end
                default: w_ev = EV_NONE;
            endcase
        end
    end

    // Candidate trackers fold in the slot visited this SCAN cycle.
    always_comb begin
        w_hit_f   = r_hit_f;
        w_hit_i   = r_hit_i;
        w_free_f  = r_free_f;
        w_free_i  = r_free_i;
        w_rel_f   = r_rel_f;
        w_rel_i   = r_rel_i;
        w_rel_age = r_rel_age;
        w_old_f   = r_old_f;
        w_old_i   = r_old_i;
        w_old_age = r_old_age;
        w_match   = r_active[r_idx]
                 && (r_tab_note[r_idx] == r_note)
                 && ((r_ev == EV_ON) || !r_sus[r_idx]);
        if (w_match && !r_hit_f) begin
            w_hit_f = 1'b1;
            w_hit_i = r_idx;
        end
        if (!r_active[r_idx] && !voice_busy[r_idx] && !r_free_f) begin
            w_free_f = 1'b1;
            w_free_i = r_idx;
        end
        if (!r_active[r_idx] && voice_busy[r_idx]
            && (!r_rel_f || (r_age[r_idx] > r_rel_age))) begin
            w_rel_f   = 1'b1;
            w_rel_i   = r_idx;
            w_rel_age = r_age[r_idx];
        end
        if (r_active[r_idx]
            && (!r_old_f || (r_age[r_idx] > r_old_age))) begin
            w_old_f   = 1'b1;
            w_old_i   = r_idx;
            w_old_age = r_age[r_idx];
        end
    end

    always_comb begin
        w_sel = r_old_i;
        if (r_hit_f)       w_sel = r_hit_i;
        else if (r_free_f) w_sel = r_free_i;
        else if (r_rel_f)  w_sel = r_rel_i;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        voice_wr_en   = 1'b0;
        voice_wr_addr = '0;
        voice_note    = '0;
        voice_vel     = '0;
        voice_gate    = 1'b0;
        w_rel_hit     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (new_msg && (w_ev != EV_NONE)) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (r_ev)
                    EV_SUS_ON:  w_next = S_IDLE;
                    EV_SUS_OFF: w_next = S_RELEASE;
                    EV_ALL_OFF: w_next = S_RELEASE;
                    default:    w_next = S_SCAN;
                endcase
            end
            S_SCAN: begin
                if (w_last) begin
                    if (r_ev == EV_ON)            w_next = S_WRITE;
                    else if (w_hit_f && !r_sustain) w_next = S_WRITE;
                    else                          w_next = S_IDLE;
                end
            end
            S_WRITE: begin
                w_next        = S_IDLE;
                voice_wr_en   = 1'b1;
                voice_wr_addr = w_sel;
                voice_note    = r_note;
                voice_vel     = (r_ev == EV_ON) ? r_vel : 7'd0;
                voice_gate    = (r_ev == EV_ON);
            end
            S_RELEASE: begin
                w_rel_hit = (r_ev == EV_ALL_OFF) ? r_active[r_idx]
                                                 : r_sus[r_idx];
                if (w_rel_hit) begin
                    voice_wr_en   = 1'b1;
                    voice_wr_addr = r_idx;
                    voice_note    = r_tab_note[r_idx];
                end
                if (w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev      <= EV_NONE;
            r_note    <= '0;
            r_vel     <= '0;
            r_idx     <= '0;
            r_active  <= '0;
            r_sus     <= '0;
            r_sustain <= 1'b0;
            r_hit_f   <= 1'b0;
            r_free_f  <= 1'b0;
            r_rel_f   <= 1'b0;
            r_old_f   <= 1'b0;
            r_hit_i   <= '0;
            r_free_i  <= '0;
            r_rel_i   <= '0;
            r_old_i   <= '0;
            r_rel_age <= '0;
            r_old_age <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_tab_note[i] <= '0;
                r_age[i]      <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (new_msg) begin
                        r_ev   <= w_ev;
                        r_note <= msg[14:8];
                        r_vel  <= msg[6:0];
                    end
                end
                S_DECODE: begin
                    r_idx    <= '0;
                    r_hit_f  <= 1'b0;
                    r_free_f <= 1'b0;
                    r_rel_f  <= 1'b0;
                    r_old_f  <= 1'b0;
                    if (r_ev == EV_SUS_ON)  r_sustain <= 1'b1;
                    if (r_ev == EV_SUS_OFF) r_sustain <= 1'b0;
                end
                S_SCAN: begin
                    r_idx     <= r_idx + ADDR_W'(1);
                    r_hit_f   <= w_hit_f;
                    r_hit_i   <= w_hit_i;
                    r_free_f  <= w_free_f;
                    r_free_i  <= w_free_i;
                    r_rel_f   <= w_rel_f;
                    r_rel_i   <= w_rel_i;
                    r_rel_age <= w_rel_age;
                    r_old_f   <= w_old_f;
                    r_old_i   <= w_old_i;
                    r_old_age <= w_old_age;
                    // Pedal held: key-up only marks the slot sustained.
                    if (w_last && (r_ev == EV_OFF) && w_hit_f && r_sustain)
                        r_sus[w_hit_i] <= 1'b1;
                end
                S_WRITE: begin
                    if (r_ev == EV_ON) begin
                        r_active[w_sel]   <= 1'b1;
                        r_sus[w_sel]      <= 1'b0;
                        r_tab_note[w_sel] <= r_note;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (ADDR_W'(i) == w_sel)
                                r_age[i] <= '0;
                            else if (r_age[i] != '1)
                                r_age[i] <= r_age[i] + AGE_W'(1);
                        end
                    end else begin
                        r_active[w_sel] <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    r_idx <= r_idx + ADDR_W'(1);
                    if (w_rel_hit) r_active[r_idx] <= 1'b0;
                    if (w_rel_hit || (r_ev == EV_ALL_OFF))
                        r_sus[r_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: event-level reference model with a
// per-cycle compare process, directed scenarios and random traffic.
module tb_midi_voice_allocator;
    localparam int          N    = 4;
    localparam int          AW   = 2;
    localparam int          AGW  = 3;
    localparam int          AMAX = (1 << AGW) - 1;
    localparam logic [15:0] MASK = 16'h0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          new_msg = 1'b0;
    logic [23:0]   msg = '0;
    logic [N-1:0]  voice_busy = '0;
    logic          voice_wr_en;
    logic [AW-1:0] voice_wr_addr;
    logic [6:0]    voice_note;
    logic [6:0]    voice_vel;
    logic          voice_gate;
    logic [N-1:0]  voices_active;
    logic          sustain_active;
    logic          busy;
    logic          dropped_msg;

    midi_voice_allocator #(
        .NUM_VOICES  (N),
        .ADDR_W      (AW),
        .CHANNEL_MASK(MASK),
        .AGE_W       (AGW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .new_msg       (new_msg),
        .msg           (msg),
        .voice_busy    (voice_busy),
        .voice_wr_en   (voice_wr_en),
        .voice_wr_addr (voice_wr_addr),
        .voice_note    (voice_note),
        .voice_vel     (voice_vel),
        .voice_gate    (voice_gate),
        .voices_active (voices_active),
        .sustain_active(sustain_active),
        .busy          (busy),
        .dropped_msg   (dropped_msg)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint c;
        int     a;
        int     n;
        int     v;
        int     g;
    } wr_t;

    wr_t        wq[$];
    longint     b_start = 0;
    longint     b_end = 0;
    bit         sus_old = 0;
    bit         sus_new = 0;
    longint     sus_at = 0;
    bit         m_act [N];
    bit         m_sus [N];
    int         m_note[N];
    int         m_age [N];
    bit [N-1:0] va_sh = '0;
    bit         cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = 0;
            m_sus[i]  = 0;
            m_note[i] = 0;
            m_age[i]  = 0;
        end
        wq.delete();
        b_start = 0;
        b_end   = 0;
        sus_old = 0;
        sus_new = 0;
        sus_at  = 0;
        va_sh   = '0;
    endfunction

    function automatic void note_on(int n, int v, longint t);
        int sel = -1;
        int best = -1;
        for (int i = 0; i < N; i++)
            if (sel < 0 && m_act[i] && m_note[i] == n) sel = i;
        for (int i = 0; i < N; i++)
            if (sel < 0 && !m_act[i] && !voice_busy[i]) sel = i;
        if (sel < 0)
            for (int i = 0; i < N; i++)
                if (!m_act[i] && voice_busy[i] && m_age[i] > best) begin
                    sel = i;
                    best = m_age[i];
                end
        if (sel < 0)
            for (int i = 0; i < N; i++)
                if (m_act[i] && m_age[i] > best) begin
                    sel = i;
                    best = m_age[i];
                end
        wq.push_back('{t + 2 + N, sel, n, v, 1});
        for (int i = 0; i < N; i++)
            m_age[i] = (i == sel) ? 0 : ((m_age[i] < AMAX) ? m_age[i] + 1 : AMAX);
        m_act[sel]  = 1;
        m_sus[sel]  = 0;
        m_note[sel] = n;
        b_start = t + 1;
        b_end   = t + 3 + N;
    endfunction

    function automatic void note_off(int n, longint t);
        int sel = -1;
        for (int i = 0; i < N; i++)
            if (sel < 0 && m_act[i] && !m_sus[i] && m_note[i] == n) sel = i;
        b_start = t + 1;
        b_end   = t + 2 + N;
        if (sel >= 0 && sus_new) begin
            m_sus[sel] = 1;
        end else if (sel >= 0) begin
            wq.push_back('{t + 2 + N, sel, n, 0, 0});
            m_act[sel] = 0;
            b_end = t + 3 + N;
        end
    endfunction

    function automatic void sweep(bit all, longint t);
        for (int i = 0; i < N; i++) begin
            if (all ? m_act[i] : m_sus[i]) begin
                wq.push_back('{t + 2 + i, i, m_note[i], 0, 0});
                m_act[i] = 0;
            end
            m_sus[i] = 0;
        end
        b_start = t + 1;
        b_end   = t + 2 + N;
    endfunction

    function automatic void model_event(logic [23:0] m, longint t);
        int hi = int'(m[23:20]);
        int ch = int'(m[19:16]);
        int d1 = int'(m[15:8]);
        int d2 = int'(m[7:0]);
        if (!MASK[ch]) return;
        if (hi == 9 && d2 != 0) begin
            note_on(d1 % 128, d2 % 128, t);
        end else if (hi == 8 || hi == 9) begin
            note_off(d1 % 128, t);
        end else if (hi == 11 && d1 == 64) begin
            sus_old = sus_new;
            sus_new = (d2 >= 64);
            sus_at  = t + 2;
            if (sus_new) begin
                b_start = t + 1;
                b_end   = t + 2;
            end else begin
                sweep(0, t);
            end
        end else if (hi == 11 && d1 == 123) begin
            sweep(1, t);
        end
    endfunction

    always @(negedge clk) begin
        bit  eb;
        bit  ew;
        wr_t w;
        if (cmp_en && !reset) begin
            eb = (cyc >= b_start) && (cyc < b_end);
            chk("busy", 32'(busy), 32'(eb));
            chk("dropped_msg", 32'(dropped_msg), 32'(new_msg && eb));
            chk("sustain_active", 32'(sustain_active),
                32'((cyc >= sus_at) ? sus_new : sus_old));
            chk("voices_active", 32'(voices_active), 32'(va_sh));
            ew = (wq.size() > 0) && (wq[0].c == cyc);
            chk("wr_en", 32'(voice_wr_en), 32'(ew));
            if (ew) begin
                w = wq.pop_front();
                chk("wr_addr", 32'(voice_wr_addr), w.a);
                chk("wr_note", 32'(voice_note), w.n);
                chk("wr_vel", 32'(voice_vel), w.v);
                chk("wr_gate", 32'(voice_gate), w.g);
                va_sh[w.a] = w.g[0];
            end else begin
                chk("wr_idle_fields",
                    32'({voice_wr_addr, voice_note, voice_vel, voice_gate}), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input longint c);
        while (cyc < c) step();
    endtask

    task automatic send(input logic [23:0] m, output longint t);
        t = cyc;
        msg = m;
        new_msg = 1'b1;
        if (!((t >= b_start) && (t < b_end))) model_event(m, t);
        step();
        new_msg = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < b_end) step();
    endtask

    task automatic sync_vb();
        for (int i = 0; i < N; i++) voice_busy[i] = m_act[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        longint t;
        longint t2;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        cmp_en = 1;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_va", 32'(voices_active), 0);
        chk("rst_wr", 32'(voice_wr_en), 0);
        chk("rst_sus", 32'(sustain_active), 0);

        send(24'h903C64, t);
        goto(t + 5);
        chk("on60_early", 32'(voice_wr_en), 0);
        step();
        chk("on60_wr", 32'(voice_wr_en), 1);
        chk("on60_addr", 32'(voice_wr_addr), 0);
        chk("on60_note", 32'(voice_note), 60);
        chk("on60_vel", 32'(voice_vel), 100);
        chk("on60_gate", 32'(voice_gate), 1);
        step();
        chk("on60_va", 32'(voices_active), 32'h1);
        chk("on60_busy", 32'(busy), 0);
        sync_vb();

        for (int k = 61; k <= 63; k++) begin
            send({8'h90, 8'(k), 8'd90}, t);
            wait_idle();
            sync_vb();
        end
        send(24'h90405A, t);
        goto(t + 6);
        chk("steal_addr", 32'(voice_wr_addr), 0);
        chk("steal_note", 32'(voice_note), 64);
        wait_idle();
        sync_vb();

        send(24'h904050, t);
        goto(t + 6);
        chk("retrig_addr", 32'(voice_wr_addr), 0);
        chk("retrig_gate", 32'(voice_gate), 1);
        wait_idle();
        chk("retrig_va", 32'(voices_active), 32'hF);

        send(24'hB0407F, t);
        wait_idle();
        chk("sus_on", 32'(sustain_active), 1);
        send(24'h803D00, t);
        goto(t + 6);
        chk("susoff61_nowr", 32'(voice_wr_en), 0);
        chk("susoff61_idle", 32'(busy), 0);
        send(24'hB04000, t);
        goto(t + 3);
        chk("rel_wr", 32'(voice_wr_en), 1);
        chk("rel_addr", 32'(voice_wr_addr), 1);
        chk("rel_note", 32'(voice_note), 61);
        chk("rel_gate", 32'(voice_gate), 0);
        goto(t + 5);
        chk("rel_busy", 32'(busy), 1);
        step();
        chk("rel_done", 32'(busy), 0);
        chk("rel_va", 32'(voices_active), 32'hD);
        sync_vb();

        send(24'h913E64, t);
        chk("mask_busy", 32'(busy), 0);
        goto(t + 6);
        chk("mask_nowr", 32'(voice_wr_en), 0);
        send(24'h903E00, t);
        goto(t + 6);
        chk("vel0_addr", 32'(voice_wr_addr), 2);
        chk("vel0_gate", 32'(voice_gate), 0);
        wait_idle();
        chk("vel0_va", 32'(voices_active), 32'h9);
        sync_vb();

        send(24'h904632, t);
        msg = 24'h904732;
        new_msg = 1'b1;
        #1;
        chk("drop_pulse", 32'(dropped_msg), 1);
        step();
        new_msg = 1'b0;
        #1;
        chk("drop_once", 32'(dropped_msg), 0);
        goto(t + 6);
        chk("drop_first_addr", 32'(voice_wr_addr), 1);
        chk("drop_first_note", 32'(voice_note), 70);
        wait_idle();
        sync_vb();

        send(24'h904832, t);
        goto(t + 3);
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        sync_vb();
        chk("rst_mid_wr", 32'(voice_wr_en), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_va", 32'(voices_active), 0);
        goto(t + 8);

        for (int k = 0; k < 400; k++) begin
            int          r;
            int          nt;
            logic [3:0]  ch;
            logic [23:0] m;
            r  = $urandom_range(0, 99);
            nt = 60 + $urandom_range(0, 9);
            ch = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (r < 45)
                m = {4'h9, ch, 8'(nt), 8'($urandom_range(1, 127))};
            else if (r < 50)
                m = {4'h9, ch, 8'(nt), 8'd0};
            else if (r < 70)
                m = {4'h8, ch, 8'(nt), 8'($urandom_range(0, 127))};
            else if (r < 82)
                m = {4'hB, ch, 8'd64, 8'($urandom_range(0, 127))};
            else if (r < 86)
                m = {4'hB, ch, 8'd123, 8'd0};
            else if (r < 93)
                m = {4'hB, ch, 8'd7, 8'd100};
            else
                m = {4'hC, ch, 8'(nt), 8'd0};
            send(m, t);
            if ($urandom_range(0, 9) == 0)
                send({4'h9, 4'd0, 8'(nt + 1), 8'd64}, t2);
            wait_idle();
            for (int i = 0; i < N; i++)
                voice_busy[i] = m_act[i] | ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 2)) step();
        end

        send(24'hB07B00, t);
        wait_idle();
        step();
        chk("alloff_va", 32'(voices_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
